// File: rtl/store_pkg.sv
// ============================================================================
// store_pkg : shared store encodings, sequencer states and fault check
// Revision  : 1.0
// ============================================================================
`default_nettype none

package store_pkg;

  localparam logic [2:0] SB = 3'h0;
  localparam logic [2:0] SH = 3'h1;
  localparam logic [2:0] SW = 3'h2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } store_state_t;

  // True when the store must be rejected without touching memory.
  function automatic logic store_fault(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      SB:      return 1'b0;
      SH:      return lane[0];
      SW:      return (lane != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_merge.sv
// ============================================================================
// store_merge : inserts store data into a memory word at the addressed lane
// Revision    : 1.0
// ============================================================================
`default_nettype none

module store_merge
  import store_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] read_word,
  output logic [XLEN-1:0] merged
);

  always_comb begin
    merged = read_word;
    case (funct3)
      SB:      merged[{lane, 3'b000} +: 8]         = operand1[7:0];
      // Halfword lanes are 0 or 2; lane[0] is a fault and never reaches here.
      SH:      merged[{lane[1], 4'b0000} +: 16]    = operand1[15:0];
      SW:      merged                              = operand1;
      default: merged                              = read_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/store_sequencer.sv
// ============================================================================
// store_sequencer : SB/SH read-modify-write and SW store sequencing controller
// Revision        : 1.0
// ============================================================================
`default_nettype none

module store_sequencer
  import store_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] base,
  input  logic [XLEN-1:0] immediate12_store,
  output logic            busy,
  output logic            done,
  output logic            fault,
  output logic            memory_read_request,
  output logic [XLEN-1:0] memory_read_address,
  input  logic            memory_read_valid,
  input  logic [XLEN-1:0] memory_read_value,
  output logic            memory_write_request,
  output logic [XLEN-1:0] memory_write_address,
  output logic [XLEN-1:0] memory_write_value,
  input  logic            memory_write_ready
);

  store_state_t    state;
  logic [2:0]      funct3_q;
  logic [1:0]      lane_q;
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] ea;
  logic [XLEN-1:0] aligned;
  logic [XLEN-1:0] merged;

  assign ea      = base + immediate12_store;
  assign aligned = {ea[XLEN-1:2], 2'b00};
  assign busy    = (state != IDLE);

  store_merge #(
    .XLEN(XLEN)
  ) u_merge (
    .funct3   (funct3_q),
    .lane     (lane_q),
    .operand1 (data_q),
    .read_word(memory_read_value),
    .merged   (merged)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= IDLE;
      funct3_q             <= 3'h0;
      lane_q               <= 2'b00;
      data_q               <= '0;
      done                 <= 1'b0;
      fault                <= 1'b0;
      memory_read_request  <= 1'b0;
      memory_read_address  <= '0;
      memory_write_request <= 1'b0;
      memory_write_address <= '0;
      memory_write_value   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            funct3_q <= funct3;
            lane_q   <= ea[1:0];
            data_q   <= operand1;
            if (store_fault(funct3, ea[1:0])) begin
              state <= FAULT;
              done  <= 1'b1;
              fault <= 1'b1;
            end else if (funct3 == SW) begin
              state                <= WRITE;
              memory_write_request <= 1'b1;
              memory_write_address <= aligned;
              memory_write_value   <= operand1;
            end else begin
              // Write address is loaded now so both ports carry the same word.
              state                <= READ;
              memory_read_request  <= 1'b1;
              memory_read_address  <= aligned;
              memory_write_address <= aligned;
            end
          end
        end
        READ: begin
          if (memory_read_valid) begin
            state                <= WRITE;
            memory_read_request  <= 1'b0;
            memory_write_request <= 1'b1;
            memory_write_value   <= merged;
          end
        end
        WRITE: begin
          if (memory_write_ready) begin
            state                <= DONE;
            memory_write_request <= 1'b0;
            done                 <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        FAULT: begin
          state <= IDLE;
          done  <= 1'b0;
          fault <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_store_sequencer.sv
// ============================================================================
// tb_store_sequencer : scoreboard bench with a wait-state memory responder
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_store_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand1, base, immediate12_store;
  logic        busy, done, fault;
  logic        memory_read_request, memory_read_valid;
  logic [31:0] memory_read_address, memory_read_value;
  logic        memory_write_request, memory_write_ready;
  logic [31:0] memory_write_address, memory_write_value;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wval;
    logic        flt;
    int          lat;
    int          rd_n;
    int          wr_n;
  } exp_t;

  exp_t sb_q[$];

  always #5 clock = ~clock;

  store_sequencer #(.XLEN(32)) dut (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .funct3              (funct3),
    .operand1            (operand1),
    .base                (base),
    .immediate12_store   (immediate12_store),
    .busy                (busy),
    .done                (done),
    .fault               (fault),
    .memory_read_request (memory_read_request),
    .memory_read_address (memory_read_address),
    .memory_read_valid   (memory_read_valid),
    .memory_read_value   (memory_read_value),
    .memory_write_request(memory_write_request),
    .memory_write_address(memory_write_address),
    .memory_write_value  (memory_write_value),
    .memory_write_ready  (memory_write_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: mask-and-shift merge, independent of lane slicing.
  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] b, input logic [31:0] imm,
                                 input logic [31:0] data, input logic [31:0] rd, input int rw, input int ww);
    exp_t        e;
    logic [31:0] ea, mask;
    int          lane;
    ea     = b + imm;
    lane   = int'(ea[1:0]);
    e.addr = ea & 32'hFFFF_FFFC;
    e.flt  = (f3 > 3'd2) || (f3 == 3'd1 && ea[0]) || (f3 == 3'd2 && ea[1:0] != 2'b00);
    if (f3 == 3'd0)      mask = 32'h0000_00FF << (8 * lane);
    else if (f3 == 3'd1) mask = 32'h0000_FFFF << (8 * lane);
    else                 mask = 32'hFFFF_FFFF;
    e.wval = (rd & ~mask) | ((data << (8 * lane)) & mask);
    if (e.flt) begin
      e.lat = 1; e.rd_n = 0; e.wr_n = 0;
    end else if (f3 == 3'd2) begin
      e.lat = 2 + ww; e.rd_n = 0; e.wr_n = ww + 1;
    end else begin
      e.lat = 3 + rw + ww; e.rd_n = rw + 1; e.wr_n = ww + 1;
    end
    return e;
  endfunction

  task automatic run_store(input logic [2:0] f3, input logic [31:0] b, input logic [31:0] imm,
                           input logic [31:0] data, input logic [31:0] rd, input int rw, input int ww,
                           input bit poke);
    exp_t e, got_e;
    int   rd_n, wr_n;
    bit   seen;
    e = model(f3, b, imm, data, rd, rw, ww);
    sb_q.push_back(e);
    funct3 = f3; base = b; immediate12_store = imm; operand1 = data; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; operand1 = ~data; base = ~b;
    rd_n = 0; wr_n = 0; seen = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      memory_read_valid  = 1'b0;
      memory_write_ready = 1'b0;
      memory_read_value  = 32'h0BAD_0BAD;
      check_eq("req_excl", {31'b0, memory_read_request & memory_write_request}, 32'd0);
      check_eq("fault_wo_done", {31'b0, fault & ~done}, 32'd0);
      if (cyc == 1) check_eq("busy", {31'b0, busy}, 32'd1);
      if (poke && cyc == 1) begin
        start = 1'b1; funct3 = 3'h3;
      end else begin
        start = 1'b0;
      end
      if (memory_read_request) begin
        rd_n++;
        if (rd_n == 1) check_eq("rd_addr", memory_read_address, e.addr);
        if (rd_n > rw) begin
          memory_read_valid = 1'b1;
          memory_read_value = rd;
        end
      end
      if (memory_write_request) begin
        wr_n++;
        if (wr_n > ww) begin
          check_eq("wr_addr", memory_write_address, e.addr);
          check_eq("wr_val", memory_write_value, e.wval);
          memory_write_ready = 1'b1;
        end
      end
      if (done) begin
        got_e = sb_q.pop_front();
        check_eq("fault", {31'b0, fault}, {31'b0, got_e.flt});
        check_eq("latency", cyc, got_e.lat);
        check_eq("rd_cycles", rd_n, got_e.rd_n);
        check_eq("wr_cycles", wr_n, got_e.wr_n);
        seen = 1'b1;
      end else begin
        @(posedge clock); #1;
      end
    end
    check_eq("done_seen", {31'b0, seen}, 32'd1);
    if (!seen && sb_q.size() > 0) sb_q.delete(0);
    start = 1'b0; memory_read_valid = 1'b0; memory_write_ready = 1'b0;
    @(posedge clock); #1;
    check_eq("idle_after", {30'b0, busy, done}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, {27'b0, busy, done, fault, memory_read_request, memory_write_request}, 32'd0);
    check_eq({tag, "_raddr"}, memory_read_address, 32'd0);
    check_eq({tag, "_waddr"}, memory_write_address, 32'd0);
    check_eq({tag, "_wval"}, memory_write_value, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; funct3 = 3'h0; operand1 = '0; base = '0; immediate12_store = '0;
    memory_read_valid = 1'b0; memory_read_value = '0; memory_write_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // Acknowledges while idle must be ignored.
    memory_read_valid = 1'b1; memory_write_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check_eq("idle_ack", {29'b0, busy, memory_read_request, memory_write_request}, 32'd0);
    end
    memory_read_valid = 1'b0; memory_write_ready = 1'b0;

    run_store(3'h2, 32'h0000_0100, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0);
    run_store(3'h2, 32'h0000_0108, 32'h0000_0000, 32'h1234_5678, 32'h0, 0, 1, 1'b0);
    run_store(3'h0, 32'h0000_0200, 32'h0000_0003, 32'h0000_00AA, 32'h1122_3344, 0, 0, 1'b0);
    run_store(3'h1, 32'h0000_0300, 32'h0000_0002, 32'h0000_BEEF, 32'h1122_3344, 2, 0, 1'b1);
    run_store(3'h2, 32'h0000_0400, 32'h0000_0001, 32'h5555_5555, 32'h0, 0, 0, 1'b0);
    run_store(3'h3, 32'h0000_0500, 32'h0000_0000, 32'h5555_5555, 32'h0, 0, 0, 1'b0);
    run_store(3'h1, 32'h0000_0300, 32'h0000_0001, 32'h0000_BEEF, 32'h0, 0, 0, 1'b0);
    run_store(3'h0, 32'hFFFF_FFFE, 32'h0000_0002, 32'h0000_0055, 32'hCAFE_F00D, 0, 0, 1'b0);
    run_store(3'h0, 32'h0000_1000, 32'hFFFF_FFFD, 32'hFFFF_FF3C, 32'hA5A5_A5A5, 1, 2, 1'b0);
    run_store(3'h1, 32'h0000_2000, 32'h0000_0000, 32'h7777_4321, 32'h8899_AABB, 0, 1, 1'b0);

    // Reset while the write is stalled.
    funct3 = 3'h2; base = 32'h0000_0500; immediate12_store = 32'h0; operand1 = 32'hFEED_FACE;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check_eq("rst_wreq", {31'b0, memory_write_request}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_all_zero("midrst");
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check_eq("midrst_nodone", {30'b0, done, busy}, 32'd0);
    end
    run_store(3'h0, 32'h0000_0600, 32'h0000_0001, 32'h0000_0099, 32'h0102_0304, 0, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_store(3'($urandom_range(0, 3)), $urandom, $urandom & 32'h0000_0FFF, $urandom, $urandom,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
    end

    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_sequencer.md
# store_sequencer

Sequencing controller for sub-word and word stores. It accepts one store operation from the execute stage and computes the effective address. SB and SH run as a read-modify-write against word-organised data memory; SW is a single write. It drives the memory read and write ports with request/acknowledge handshakes, flags illegal or misaligned stores, and reports completion to the core's issue logic.

## Interface
Parameters:
- XLEN, 32: data and address width. Only 32 is supported.

Ports:
- clock  input  1  single system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle store request; sampled only while idle.
- funct3  input  3  store type: 0 = SB, 1 = SH, 2 = SW; all others are illegal.
- operand1  input  32  store data (rs2 value).
- base  input  32  base address (rs1 value).
- immediate12_store  input  32  already sign-extended S-type offset.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.
- fault  output  1  one-cycle pulse, coincident with done, for an illegal funct3 or a misaligned address.
- memory_read_request  output  1  read request, held until memory_read_valid.
- memory_read_address  output  32  word-aligned read address.
- memory_read_valid  input  1  read data valid; acknowledges the request.
- memory_read_value  input  32  read data word.
- memory_write_request  output  1  write request, held until memory_write_ready.
- memory_write_address  output  32  word-aligned write address.
- memory_write_value  output  32  full merged word to write.
- memory_write_ready  input  1  write accepted.

## Operation
- Effective address: ea = base + immediate12_store, 32-bit modulo (carry dropped). Aligned address is {ea[31:2], 2'b00}. Lane k = ea[1:0].
- On start while IDLE, capture funct3, operand1 and ea into registers. Inputs are ignored after the capture cycle. start while busy is dropped silently.
- Fault conditions (no memory access is issued):
  - funct3 not in {0, 1, 2};
  - SH with ea[0] = 1;
  - SW with ea[1:0] != 0.
- FSM states: IDLE, READ, WRITE, DONE, FAULT.
  - IDLE, on start: fault condition → FAULT; SW → WRITE; SB/SH → READ.
  - READ: memory_read_request = 1. On memory_read_valid, register the merged word → WRITE.
  - WRITE: memory_write_request = 1. On memory_write_ready → DONE.
  - DONE: done = 1 → IDLE.
  - FAULT: done = 1 and fault = 1 → IDLE.
- Merge rules:
  - SB: memory_read_value with bits [8k+7:8k] replaced by operand1[7:0].
  - SH: bits [8k+15:8k] replaced by operand1[15:0], where k is 0 or 2.
  - SW: write value = operand1 unmodified.
- Address and write-value outputs are registered and stay stable for the whole time their request is asserted. Read and write addresses are equal for a given operation.
- Memory acknowledges arriving while the matching request is low are ignored.

## Timing
- Reset value of every output is 0. State returns to IDLE and captured registers clear.
- Reset mid-operation: outstanding requests drop on the next edge, and no done is produced for the aborted store.
- Latency from the start edge to the done cycle, with zero-wait memory (acknowledge in the first request cycle):
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Fault: 1 cycle.
- Each wait cycle on memory_read_valid or memory_write_ready adds one cycle.
- A new start is accepted in the cycle after done, once state is IDLE again. Back-to-back SW stores therefore sustain one store per 3 cycles.
- memory_read_request and memory_write_request are never high in the same cycle.

## Structure
- Shared package store_pkg:
  - funct3 constants SB = 3'h0, SH = 3'h1, SW = 3'h2;
  - the state enum store_state_t {IDLE, READ, WRITE, DONE, FAULT}.
- One sub-module, store_merge: purely combinational. Inputs are funct3, lane, operand1 and the read word; output is the merged word. It is reusable by the load/store unit.
- FSM and capture registers live in store_sequencer.

## Test plan
- SW, base = 0x100, imm = 0x4, data = 0xDEADBEEF, ready immediate:
  - write address 0x104, value 0xDEADBEEF;
  - done on the second cycle after start, no read issued.
- SB, base = 0x200, imm = 0x3, data = 0x000000AA, read returns 0x11223344:
  - read and write address 0x200;
  - write value 0xAA223344;
  - done on the third cycle.
- SH, ea = 0x302, data = 0x0000BEEF, read returns 0x11223344 after 2 wait cycles:
  - write value 0xBEEF3344;
  - read request held for 3 cycles;
  - done on the fifth cycle.
- Misaligned SW at ea = 0x401, and funct3 = 3:
  - each gives done = fault = 1 one cycle after start;
  - no read or write request asserted.
- Address wrap: base = 0xFFFFFFFE, imm = 0x2, SB → aligned address 0x00000000.
- Reset asserted in WRITE with memory_write_ready low:
  - next cycle all outputs 0, busy = 0;
  - no done;
  - the following start is accepted normally.
